// File: rtl/control.sv
// Single-cycle control unit: combinational decode of instruction_in, with the program counter updated on each rising edge.
// Defining RELATIVE_BRANCH_EN makes branch targets PC + ext_in; otherwise the target is the absolute operand.
module control #(
  parameter int OPERAND_WIDTH     = 11,
  parameter int INSTRUCTION_WIDTH = 16
) (
  input  logic                         clock_in,
  input  logic                         reset_in,
  input  logic [INSTRUCTION_WIDTH-1:0] instruction_in,
  input  logic [INSTRUCTION_WIDTH-1:0] ext_in,
  input  logic                         status_Z_in,
  input  logic                         status_N_in,
  output logic [OPERAND_WIDTH-1:0]     address_out,
  output logic [OPERAND_WIDTH-1:0]     operand_out,
  output logic                         sel_B_out,
  output logic                         alu_op_out,
  output logic                         data_memory_wr_out,
  output logic                         acc_wr_out,
  output logic                         status_wr_out,
  output logic                         acc_reset_out,
  output logic                         status_reset_out,
  output logic [1:0]                   sel_A_out
);
  localparam int OPCODE_WIDTH = INSTRUCTION_WIDTH - OPERAND_WIDTH;

  localparam logic [OPCODE_WIDTH-1:0] OP_HLT  = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_STO  = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_LD   = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDI  = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUBI = OPCODE_WIDTH'(7);
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ  = OPCODE_WIDTH'(8);
  localparam logic [OPCODE_WIDTH-1:0] OP_BNE  = OPCODE_WIDTH'(9);
  localparam logic [OPCODE_WIDTH-1:0] OP_BGT  = OPCODE_WIDTH'(10);
  localparam logic [OPCODE_WIDTH-1:0] OP_BGE  = OPCODE_WIDTH'(11);
  localparam logic [OPCODE_WIDTH-1:0] OP_BLT  = OPCODE_WIDTH'(12);
  localparam logic [OPCODE_WIDTH-1:0] OP_BLE  = OPCODE_WIDTH'(13);
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP  = OPCODE_WIDTH'(14);

  localparam logic [1:0] SEL_A_MEM = 2'b00;
  localparam logic [1:0] SEL_A_IMM = 2'b01;
  localparam logic [1:0] SEL_A_ALU = 2'b10;

  logic [OPCODE_WIDTH-1:0]  opcode;
  logic [OPERAND_WIDTH-1:0] operand;
  logic [OPERAND_WIDTH-1:0] pc;
  logic [OPERAND_WIDTH-1:0] pc_inc;
  logic [OPERAND_WIDTH-1:0] pc_next;
  logic [OPERAND_WIDTH-1:0] target;
  logic                     taken;
  logic                     halt;
  logic                     dm_wr;
  logic                     acc_wr;
  logic                     st_wr;
  logic                     unused_ext;

  assign opcode      = instruction_in[INSTRUCTION_WIDTH-1:OPERAND_WIDTH];
  assign operand     = instruction_in[OPERAND_WIDTH-1:0];
  assign operand_out = operand;
  assign address_out = pc;
  assign pc_inc      = pc + OPERAND_WIDTH'(1);

`ifdef RELATIVE_BRANCH_EN
  assign target = pc + ext_in[OPERAND_WIDTH-1:0];
`else
  assign target = operand;
`endif
  // Upper extender bits (and the whole bus in absolute mode) carry no information here.
  assign unused_ext = ^ext_in;

  always_comb begin
    sel_B_out  = 1'b0;
    alu_op_out = 1'b0;
    sel_A_out  = SEL_A_MEM;
    dm_wr      = 1'b0;
    acc_wr     = 1'b0;
    st_wr      = 1'b0;
    taken      = 1'b0;
    halt       = 1'b0;
    case (opcode)
      OP_HLT: halt = 1'b1;
      OP_STO: dm_wr = 1'b1;
      OP_LD: begin
        acc_wr = 1'b1;
        st_wr  = 1'b1;
      end
      OP_LDI: begin
        sel_A_out = SEL_A_IMM;
        acc_wr    = 1'b1;
        st_wr     = 1'b1;
      end
      OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: begin
        sel_A_out  = SEL_A_ALU;
        sel_B_out  = (opcode == OP_ADDI) || (opcode == OP_SUBI);
        alu_op_out = (opcode == OP_SUB) || (opcode == OP_SUBI);
        acc_wr     = 1'b1;
        st_wr      = 1'b1;
      end
      OP_BEQ: taken = status_Z_in;
      OP_BNE: taken = !status_Z_in;
      OP_BGT: taken = !status_Z_in && !status_N_in;
      OP_BGE: taken = !status_N_in;
      OP_BLT: taken = status_N_in;
      OP_BLE: taken = status_Z_in || status_N_in;
      OP_JMP: taken = 1'b1;
      default: ;
    endcase
  end

  // Write enables are gated so nothing is committed while the datapath is held in reset.
  assign data_memory_wr_out = dm_wr & reset_in;
  assign acc_wr_out         = acc_wr & reset_in;
  assign status_wr_out      = st_wr & reset_in;
  assign acc_reset_out      = ~reset_in;
  assign status_reset_out   = ~reset_in;

  assign pc_next = halt ? pc : (taken ? target : pc_inc);

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      pc <= '0;
    end else begin
      pc <= pc_next;
    end
  end
endmodule

// File: tb/tb_control.sv
// Bench for control: decode table, hand-written PC sequences and a random run against an arithmetic model.
module tb_control;
  logic        clock_in = 1'b0;
  logic        reset_in;
  logic [15:0] instruction_in;
  logic [15:0] ext_in;
  logic        status_Z_in;
  logic        status_N_in;
  logic [10:0] address_out;
  logic [10:0] operand_out;
  logic        sel_B_out, alu_op_out, data_memory_wr_out, acc_wr_out, status_wr_out;
  logic        acc_reset_out, status_reset_out;
  logic [1:0]  sel_A_out;

  int total = 0;
  int bad = 0;
  int model_pc = 0;

  control dut (
    .clock_in(clock_in), .reset_in(reset_in), .instruction_in(instruction_in), .ext_in(ext_in),
    .status_Z_in(status_Z_in), .status_N_in(status_N_in), .address_out(address_out),
    .operand_out(operand_out), .sel_B_out(sel_B_out), .alu_op_out(alu_op_out),
    .data_memory_wr_out(data_memory_wr_out), .acc_wr_out(acc_wr_out), .status_wr_out(status_wr_out),
    .acc_reset_out(acc_reset_out), .status_reset_out(status_reset_out), .sel_A_out(sel_A_out)
  );

  always #5 clock_in = ~clock_in;

  // Control word layout: {sel_A[1:0], sel_B, alu_op, dm_wr, acc_wr, status_wr, acc_reset, status_reset}
  localparam logic [8:0] C_NONE = 9'b000000000;
  localparam logic [8:0] C_STO  = 9'b000010000;
  localparam logic [8:0] C_LD   = 9'b000001100;
  localparam logic [8:0] C_LDI  = 9'b010001100;
  localparam logic [8:0] C_ADD  = 9'b100001100;
  localparam logic [8:0] C_ADDI = 9'b101001100;
  localparam logic [8:0] C_SUB  = 9'b100101100;
  localparam logic [8:0] C_SUBI = 9'b101101100;

  typedef struct {
    logic [15:0] instr;
    logic        z;
    logic        n;
    logic [8:0]  ctl;
    int          kind;   // 0: PC+1, 1: branch target, 2: hold
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] ctl_word();
    return {sel_A_out, sel_B_out, alu_op_out, data_memory_wr_out, acc_wr_out, status_wr_out,
            acc_reset_out, status_reset_out};
  endfunction

  function automatic int model_ctl(input int opc);
    int acc, sel_a, sel_b, alu, dm;
    acc   = (opc >= 2 && opc <= 7) ? 1 : 0;
    dm    = (opc == 1) ? 1 : 0;
    sel_a = (opc == 3) ? 1 : ((opc >= 4 && opc <= 7) ? 2 : 0);
    sel_b = (opc == 5 || opc == 7) ? 1 : 0;
    alu   = (opc == 6 || opc == 7) ? 1 : 0;
    return sel_a * 128 + sel_b * 64 + alu * 32 + dm * 16 + acc * 8 + acc * 4;
  endfunction

  function automatic int branch_target(input int pc, input int instr, input int ext);
`ifdef RELATIVE_BRANCH_EN
    return (pc + (ext % 2048)) % 2048;
`else
    return instr % 2048;
`endif
  endfunction

  function automatic int model_next(input int pc, input int instr, input int ext, input bit z, input bit n);
    int opc;
    bit tk;
    opc = instr / 2048;
    case (opc)
      0:  return pc;
      8:  tk = z;
      9:  tk = !z;
      10: tk = !z && !n;
      11: tk = !n;
      12: tk = n;
      13: tk = z || n;
      14: tk = 1;
      default: tk = 0;
    endcase
    return tk ? branch_target(pc, instr, ext) : (pc + 1) % 2048;
  endfunction

  // Runs one instruction starting just after a rising edge; checks decode, then the captured PC.
  task automatic step(input string name, input int instr, input int ext, input bit z, input bit n);
    int nxt;
    instruction_in = instr[15:0];
    ext_in = ext[15:0];
    status_Z_in = z;
    status_N_in = n;
    #1;
    check({name, "/ctl"}, ctl_word(), model_ctl(instr / 2048));
    check({name, "/operand"}, operand_out, instr % 2048);
    nxt = model_next(model_pc, instr, ext, z, n);
    @(posedge clock_in);
    #1;
    model_pc = nxt;
    check({name, "/pc"}, address_out, model_pc);
  endtask

  task automatic goto_pc(input int addr);
    step("goto", 16'h7000 + addr, (addr - model_pc) & 16'hFFFF, 1'b0, 1'b0);
  endtask

  vec_t tab[$];

  initial begin
    tab.push_back('{16'h0000, 1'b0, 1'b0, C_NONE, 2});
    tab.push_back('{16'h0805, 1'b0, 1'b0, C_STO,  0});
    tab.push_back('{16'h1011, 1'b1, 1'b0, C_LD,   0});
    tab.push_back('{16'h1922, 1'b0, 1'b1, C_LDI,  0});
    tab.push_back('{16'h2033, 1'b0, 1'b0, C_ADD,  0});
    tab.push_back('{16'h2805, 1'b0, 1'b0, C_ADDI, 0});
    tab.push_back('{16'h3044, 1'b1, 1'b1, C_SUB,  0});
    tab.push_back('{16'h3855, 1'b0, 1'b0, C_SUBI, 0});
    tab.push_back('{16'h4003, 1'b1, 1'b0, C_NONE, 1});
    tab.push_back('{16'h4003, 1'b0, 1'b0, C_NONE, 0});
    tab.push_back('{16'h4866, 1'b0, 1'b1, C_NONE, 1});
    tab.push_back('{16'h4866, 1'b1, 1'b0, C_NONE, 0});
    tab.push_back('{16'h5000, 1'b0, 1'b0, C_NONE, 1});
    tab.push_back('{16'h5000, 1'b1, 1'b0, C_NONE, 0});
    tab.push_back('{16'h5000, 1'b0, 1'b1, C_NONE, 0});
    tab.push_back('{16'h5877, 1'b1, 1'b0, C_NONE, 1});
    tab.push_back('{16'h5877, 1'b0, 1'b1, C_NONE, 0});
    tab.push_back('{16'h6088, 1'b0, 1'b1, C_NONE, 1});
    tab.push_back('{16'h6088, 1'b1, 1'b0, C_NONE, 0});
    tab.push_back('{16'h6800, 1'b1, 1'b0, C_NONE, 1});
    tab.push_back('{16'h6800, 1'b0, 1'b1, C_NONE, 1});
    tab.push_back('{16'h6800, 1'b0, 1'b0, C_NONE, 0});
    tab.push_back('{16'h7099, 1'b0, 1'b1, C_NONE, 1});
    tab.push_back('{16'h7812, 1'b1, 1'b1, C_NONE, 0});
    tab.push_back('{16'h8000, 1'b0, 1'b0, C_NONE, 0});
    tab.push_back('{16'hF812, 1'b1, 1'b0, C_NONE, 0});

    // Reset phase: outputs forced regardless of instruction, PC stays at 0 across edges.
    reset_in = 1'b0;
    instruction_in = 16'h0805;
    ext_in = 16'h0000;
    status_Z_in = 1'b0;
    status_N_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      instruction_in = (i == 0) ? 16'h0805 : ((i == 1) ? 16'h1000 : 16'h2805);
      @(posedge clock_in);
      #1;
      check($sformatf("reset%0d/pc", i), address_out, 11'h000);
      check($sformatf("reset%0d/wr_rst", i), ctl_word() & 9'h01F, 9'h003);
    end

    // First edge after release executes address 0.
    reset_in = 1'b1;
    model_pc = 0;
    step("sto5", 16'h0805, 0, 1'b0, 1'b0);
    check("sto5/pc_is_1", address_out, 11'h001);
    step("addi5", 16'h2805, 0, 1'b0, 1'b0);

    // Decode table, every opcode class and flag combination.
    for (int i = 0; i < tab.size(); i++) begin
      int ext, exp_pc;
      ext = $urandom_range(0, 65535);
      instruction_in = tab[i].instr;
      ext_in = ext[15:0];
      status_Z_in = tab[i].z;
      status_N_in = tab[i].n;
      #1;
      check($sformatf("vec%0d/ctl", i), ctl_word(), tab[i].ctl);
      check($sformatf("vec%0d/operand", i), operand_out, tab[i].instr[10:0]);
      if (tab[i].kind == 2) exp_pc = model_pc;
      else if (tab[i].kind == 1) exp_pc = branch_target(model_pc, tab[i].instr, ext);
      else exp_pc = (model_pc + 1) % 2048;
      @(posedge clock_in);
      #1;
      model_pc = exp_pc;
      check($sformatf("vec%0d/pc", i), address_out, model_pc);
    end

    // BEQ from PC=4, taken and not taken (ext=-1 gives the same target in relative builds).
    goto_pc(4);
    step("beq_z1", 16'h4003, 16'hFFFF, 1'b1, 1'b0);
    check("beq_z1/abs3", address_out, 11'd3);
    goto_pc(4);
    step("beq_z0", 16'h4003, 16'hFFFF, 1'b0, 1'b0);
    check("beq_z0/pc5", address_out, 11'd5);

    // PC wrap, then HLT holds for three edges.
    goto_pc(11'h7FF);
    step("ld_wrap", 16'h1000, 0, 1'b0, 1'b0);
    check("ld_wrap/zero", address_out, 11'h000);
    goto_pc(11'h123);
    for (int i = 0; i < 3; i++) step($sformatf("hlt%0d", i), 16'h0000, 0, 1'b0, 1'b0);
    check("hlt/held", address_out, 11'h123);

    // A flag change late in the cycle decides the branch at the next edge.
    goto_pc(4);
    instruction_in = 16'h4003;
    ext_in = 16'hFFFF;
    status_Z_in = 1'b0;
    @(negedge clock_in);
    status_Z_in = 1'b1;
    @(posedge clock_in);
    #1;
    model_pc = 3;
    check("late_flag/pc", address_out, 11'd3);

`ifdef RELATIVE_BRANCH_EN
    goto_pc(10);
    step("rel_jmp", 16'h7000, 16'hFFFE, 1'b0, 1'b0);
    check("rel_jmp/pc8", address_out, 11'd8);
`endif

    // Randomised instruction stream against the model.
    for (int i = 0; i < 300; i++) begin
      step($sformatf("rnd%0d", i), $urandom_range(0, 65535), $urandom_range(0, 65535),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset mid-run clears the PC without a clock edge.
    goto_pc(11'h2AA);
    instruction_in = 16'h1000;
    reset_in = 1'b0;
    #1;
    check("async_rst/pc", address_out, 11'h000);
    check("async_rst/wr_rst", ctl_word() & 9'h01F, 9'h003);
    @(posedge clock_in);
    #1;
    reset_in = 1'b1;
    model_pc = 0;
    step("after_rst", 16'h0805, 0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
